// File: rtl/qft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qft_pkg
// Description : Shared types and index helpers for the QFT permutation
//               sequencer (pass kinds, FSM states, bit insert/remove/reverse).
// Revision    : 1.0 - initial release
// ============================================================================
package qft_pkg;

    typedef enum logic [1:0] {
        GATHER  = 2'd0,
        SCATTER = 2'd1,
        BITREV  = 2'd2
    } pass_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Insert bit b at position t of k; bits at and above t move up by one.
    function automatic int insert_bit(input int k, input int t, input int b);
        int low_mask;
        low_mask = (1 << t) - 1;
        return ((k >> t) << (t + 1)) | ((b & 1) << t) | (k & low_mask);
    endfunction

    // Delete bit t of j; bits above t move down by one.
    function automatic int remove_bit(input int j, input int t);
        int low_mask;
        low_mask = (1 << t) - 1;
        return ((j >> (t + 1)) << t) | (j & low_mask);
    endfunction

    // Reverse the low nq bits of j.
    function automatic int bit_rev(input int j, input int nq);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < nq) begin
                r = r | (((j >> (nq - 1 - i)) & 1) << i);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qft_perm_seq_perm_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : perm_pattern_gen
// Description : Combinational crossbar select generator. Maps a pass kind
//               and target qubit to the full per-lane select array.
// Revision    : 1.0 - initial release
// ============================================================================
module perm_pattern_gen
    import qft_pkg::*;
#(
    parameter int N     = 8,
    parameter int NQ    = $clog2(N),
    parameter int SEL_W = $clog2(N)
) (
    input  pass_kind_e        pass_kind,
    input  logic [NQ-1:0]     target,
    output logic [SEL_W-1:0]  sel [N]
);

    // Build the select pattern; identity is the fallback for unused kinds.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            sel[j] = SEL_W'(j);
        end
        case (pass_kind)
            GATHER: begin
                // Pair (i, i^(1<<t)) lands on lanes 2k / 2k+1.
                for (int k = 0; k < N / 2; k++) begin
                    sel[2*k]   = SEL_W'(insert_bit(k, int'(target), 0));
                    sel[2*k+1] = SEL_W'(insert_bit(k, int'(target), 1));
                end
            end
            SCATTER: begin
                // Inverse of GATHER: lane j reads back from its gathered slot.
                for (int j = 0; j < N; j++) begin
                    sel[j] = SEL_W'(2 * remove_bit(j, int'(target))
                                    + ((j >> int'(target)) & 1));
                end
            end
            BITREV: begin
                for (int j = 0; j < N; j++) begin
                    sel[j] = SEL_W'(bit_rev(j, NQ));
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/qft_perm_seq.sv
`default_nettype none
// ============================================================================
// Module      : qft_perm_seq
// Description : Permutation sequencer for the QFT amplitude crossbar. Issues
//               GATHER(t)/SCATTER(t) for t = NQ-1 .. 0 over a valid/ready
//               handshake, optionally followed by a BITREV pass.
//               Build option: define QFT_BITREV_EN to append the BITREV pass.
// Revision    : 1.0 - initial release
// ============================================================================
module qft_perm_seq
    import qft_pkg::*;
#(
    parameter int N     = 8,
    parameter int NQ    = $clog2(N),
    parameter int SEL_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [SEL_W-1:0]  sel [N],
    output logic              sel_valid,
    input  logic              sel_ready,
    output logic [NQ-1:0]     target,
    output logic [1:0]        pass_kind,
    output logic              busy,
    output logic              done
);

`ifdef QFT_BITREV_EN
    localparam int c_num_passes = 2 * NQ + 1;
`else
    localparam int c_num_passes = 2 * NQ;
`endif
    localparam int c_pass_w = $clog2(c_num_passes + 1);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [c_pass_w-1:0]   r_pass;
    logic [c_pass_w-1:0]   w_pass_nxt;
    logic                  w_valid_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    pass_kind_e            w_kind_nxt;
    logic [NQ-1:0]         w_target_nxt;
    logic                  w_accept;
    logic [SEL_W-1:0]      w_pat [N];

    // Pass index p: even = GATHER, odd = SCATTER, index 2*NQ = BITREV.
    function automatic pass_kind_e kind_of(input int p);
        if (p >= 2 * NQ) begin
            return BITREV;
        end
        return ((p % 2) == 1) ? SCATTER : GATHER;
    endfunction

    // Target descends from NQ-1 to 0, two passes per qubit.
    function automatic logic [NQ-1:0] target_of(input int p);
        if (p >= 2 * NQ) begin
            return '0;
        end
        return NQ'(NQ - 1 - p / 2);
    endfunction

    assign w_accept = sel_valid & sel_ready;

    perm_pattern_gen #(
        .N     (N),
        .NQ    (NQ),
        .SEL_W (SEL_W)
    ) u_pattern (
        .pass_kind (w_kind_nxt),
        .target    (w_target_nxt),
        .sel       (w_pat)
    );

    // Next-state and next-output decode; all outputs are registered below.
    always_comb begin
        w_state_nxt  = r_state;
        w_pass_nxt   = r_pass;
        w_valid_nxt  = sel_valid;
        w_busy_nxt   = busy;
        w_done_nxt   = 1'b0;
        w_kind_nxt   = pass_kind_e'(pass_kind);
        w_target_nxt = target;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_RUN;
                    w_pass_nxt   = '0;
                    w_valid_nxt  = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_kind_nxt   = kind_of(0);
                    w_target_nxt = target_of(0);
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (r_pass == c_pass_w'(c_num_passes - 1)) begin
                        w_state_nxt  = ST_DONE;
                        w_pass_nxt   = '0;
                        w_valid_nxt  = 1'b0;
                        w_busy_nxt   = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_kind_nxt   = GATHER;
                        w_target_nxt = '0;
                    end else begin
                        w_pass_nxt   = r_pass + 1'b1;
                        w_kind_nxt   = kind_of(int'(r_pass) + 1);
                        w_target_nxt = target_of(int'(r_pass) + 1);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_pass_nxt   = '0;
                w_valid_nxt  = 1'b0;
                w_busy_nxt   = 1'b0;
                w_kind_nxt   = GATHER;
                w_target_nxt = '0;
            end
        endcase
    end

    // State, counter and output registers; sel is identity whenever no pass is offered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pass    <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass_kind <= 2'd0;
            target    <= '0;
            for (int j = 0; j < N; j++) begin
                sel[j] <= SEL_W'(j);
            end
        end else begin
            r_state   <= w_state_nxt;
            r_pass    <= w_pass_nxt;
            sel_valid <= w_valid_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
            pass_kind <= w_kind_nxt;
            target    <= w_target_nxt;
            for (int j = 0; j < N; j++) begin
                sel[j] <= w_valid_nxt ? w_pat[j] : SEL_W'(j);
            end
        end
    end

endmodule
`default_nettype wire
